// File: rtl/gemm_pkg.sv
// Shared definitions for the gemm engine and its local tile scratchpad.
package gemm_pkg;

   localparam int unsigned LANES      = 4;
   localparam int unsigned LANE_W     = 32;
   localparam int unsigned LANE_SEL_W = 2;

   // gemm_control field positions
   localparam int unsigned CTRL_W        = 5;
   localparam int unsigned CTRL_WE_LSB   = 0;
   localparam int unsigned CTRL_RSVD_BIT = 4;

   typedef enum logic [1:0] {
      StIdle,
      StPend,
      StDone
   } tile_mem_state_e;

   function automatic logic even_parity(input logic [LANE_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/tile_mem_lane.sv
// One 32-bit lane of the tile scratchpad: single-port array, registered read.
// GEMM_TILE_MEM_PARITY_EN adds a stored even-parity bit checked on every read.
module tile_mem_lane
   import gemm_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [LANE_W-1:0] wdata,
   output logic [LANE_W-1:0] rd_data,
   output logic              par_err
);

`ifdef GEMM_TILE_MEM_PARITY_EN
   localparam int unsigned EW = LANE_W + 1;
`else
   localparam int unsigned EW = LANE_W;
`endif

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] entry;
   logic [EW-1:0] rd_q;

`ifdef GEMM_TILE_MEM_PARITY_EN
   assign entry = {even_parity(wdata), wdata};
`else
   assign entry = wdata;
`endif

   // Storage is deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem_q[addr] <= entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
      end else if (en && !we) begin
         rd_q <= mem_q[addr];
      end
   end

   assign rd_data = rd_q[LANE_W-1:0];

`ifdef GEMM_TILE_MEM_PARITY_EN
   logic rd_chk_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_chk_q <= 1'b0;
      end else begin
         rd_chk_q <= en && !we;
      end
   end

   assign par_err = rd_chk_q && (even_parity(rd_q[LANE_W-1:0]) != rd_q[LANE_W]);
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: rtl/gemm_tile_mem.sv
// Tile scratchpad behind the gemm engine with a lower-priority 32-bit host port.
// Optional parity storage/checking is enabled by GEMM_TILE_MEM_PARITY_EN.
module gemm_tile_mem
   import gemm_pkg::*;
#(
   parameter int unsigned DEPTH_LINES = 1024,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         gemm_en,
   input  logic                         gemm_rdwr,
   input  logic [31:0]                  gemm_addr,
   input  logic [CTRL_W-1:0]            gemm_control,
   input  logic [LANES-1:0][LANE_W-1:0] gemm_wr_data,
   output logic [LANES*LANE_W-1:0]      gemm_rd_data,
   input  logic                         sys_en,
   input  logic                         sys_rdwr,
   input  logic [31:0]                  sys_addr,
   input  logic [LANE_W-1:0]            sys_wr_data,
   output logic                         sys_ready,
   output logic                         sys_done,
   output logic [LANE_W-1:0]            sys_rd_data,
   output logic [STALL_CNT_W-1:0]       stall_count,
   output logic                         parity_err
);

   localparam int unsigned IW = $clog2(DEPTH_LINES);

   tile_mem_state_e         state_q;
   logic                    rdwr_q;
   logic [IW-1:0]           idx_q;
   logic [LANE_SEL_W-1:0]   lane_q;
   logic [LANE_W-1:0]       wdata_q;
   logic                    sys_ready_q;
   logic                    sys_done_q;
   logic [STALL_CNT_W-1:0]  stall_count_q;

   logic                    host_exec;
   logic [IW-1:0]           lane_addr;
   logic [LANES-1:0]        lane_en;
   logic [LANES-1:0]        lane_we;
   logic [LANES-1:0]        lane_perr;
   logic [LANES-1:0][LANE_W-1:0] lane_wdata;
   logic [LANES-1:0][LANE_W-1:0] lane_rd;

   logic                    gemm_rd_q;
   logic [LANES*LANE_W-1:0] gemm_hold_q;

   // Engine owns the port whenever gemm_en is high; host only runs in idle engine cycles.
   assign host_exec = (state_q == StPend) && !gemm_en && !rst;
   assign lane_addr = gemm_en ? gemm_addr[4 +: IW] : idx_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_en[i]    = gemm_en ? (!gemm_rdwr || gemm_control[CTRL_WE_LSB + i])
                                     : (host_exec && (lane_q == LANE_SEL_W'(i)));
      assign lane_we[i]    = gemm_en ? gemm_rdwr : rdwr_q;
      assign lane_wdata[i] = gemm_en ? gemm_wr_data[i] : wdata_q;

      tile_mem_lane #(
         .DEPTH (DEPTH_LINES),
         .AW    (IW)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .en      (lane_en[i]),
         .we      (lane_we[i]),
         .addr    (lane_addr),
         .wdata   (lane_wdata[i]),
         .rd_data (lane_rd[i]),
         .par_err (lane_perr[i])
      );
   end

   // Host reads also load the lane registers, so the engine view is held separately.
   assign gemm_rd_data = gemm_rd_q ? lane_rd : gemm_hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gemm_rd_q   <= 1'b0;
         gemm_hold_q <= '0;
      end else begin
         gemm_rd_q   <= gemm_en && !gemm_rdwr;
         gemm_hold_q <= gemm_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         sys_ready_q   <= 1'b1;
         sys_done_q    <= 1'b0;
         stall_count_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sys_en) begin
                  rdwr_q      <= sys_rdwr;
                  idx_q       <= sys_addr[4 +: IW];
                  lane_q      <= sys_addr[3:2];
                  wdata_q     <= sys_wr_data;
                  sys_ready_q <= 1'b0;
                  state_q     <= StPend;
               end
            end
            StPend: begin
               if (gemm_en) begin
                  if (stall_count_q != '1) begin
                     stall_count_q <= stall_count_q + 1'b1;
                  end
               end else begin
                  sys_done_q <= 1'b1;
                  state_q    <= StDone;
               end
            end
            StDone: begin
               sys_done_q  <= 1'b0;
               sys_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: begin
               sys_done_q  <= 1'b0;
               sys_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign sys_ready   = sys_ready_q;
   assign sys_done    = sys_done_q;
   assign sys_rd_data = (sys_done_q && !rdwr_q) ? lane_rd[lane_q] : '0;
   assign stall_count = stall_count_q;

`ifdef GEMM_TILE_MEM_PARITY_EN
   logic parity_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else if (|lane_perr) begin
         parity_err_q <= 1'b1;
      end
   end

   assign parity_err = parity_err_q;
`else
   logic unused_perr;
   assign unused_perr = |lane_perr;
   assign parity_err  = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = ^{gemm_addr[31:4+IW], gemm_addr[3:0], gemm_control[CTRL_RSVD_BIT],
                        sys_addr[31:4+IW], sys_addr[1:0]};

endmodule

// File: tb/tb_gemm_tile_mem.sv
// Scoreboard bench for gemm_tile_mem: reference model predicts, a monitor compares.
// Covers the parity path as well when GEMM_TILE_MEM_PARITY_EN is defined.
module tb_gemm_tile_mem;

   localparam int unsigned DL = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              gemm_en;
   logic              gemm_rdwr;
   logic [31:0]       gemm_addr;
   logic [4:0]        gemm_control;
   logic [3:0][31:0]  gemm_wr_data;
   logic [127:0]      gemm_rd_data;
   logic              sys_en;
   logic              sys_rdwr;
   logic [31:0]       sys_addr;
   logic [31:0]       sys_wr_data;
   logic              sys_ready;
   logic              sys_done;
   logic [31:0]       sys_rd_data;
   logic [15:0]       stall_count;
   logic              parity_err;

   gemm_tile_mem #(
      .DEPTH_LINES (DL),
      .STALL_CNT_W (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .gemm_en      (gemm_en),
      .gemm_rdwr    (gemm_rdwr),
      .gemm_addr    (gemm_addr),
      .gemm_control (gemm_control),
      .gemm_wr_data (gemm_wr_data),
      .gemm_rd_data (gemm_rd_data),
      .sys_en       (sys_en),
      .sys_rdwr     (sys_rdwr),
      .sys_addr     (sys_addr),
      .sys_wr_data  (sys_wr_data),
      .sys_ready    (sys_ready),
      .sys_done     (sys_done),
      .sys_rd_data  (sys_rd_data),
      .stall_count  (stall_count),
      .parity_err   (parity_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
      logic [15:0] stall;
   } host_exp_t;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   host_exp_t    hq[$];
   logic [127:0] gq[$];
   logic [127:0] g_last = '0;
   logic [31:0]  mdl [DL][4];
   int unsigned  cyc = 0;
   bit           mon_on = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      gemm_en = 1'b0; gemm_rdwr = 1'b0; gemm_addr = '0; gemm_control = '0; gemm_wr_data = '0;
      sys_en = 1'b0; sys_rdwr = 1'b0; sys_addr = '0; sys_wr_data = '0;
   endtask

   // Reference model: memory as a plain array; a host request executes at the first
   // edge after acceptance with the engine idle, and completes on the following cycle.
   bit          h_pend = 1'b0;
   bit          h_rdwr;
   int          h_idx;
   int          h_lane;
   logic [31:0] h_wdata;
   logic [15:0] m_stall = '0;
   int unsigned next_acc = 0;

   initial begin
      host_exp_t e;
      int gi;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            h_pend   = 1'b0;
            m_stall  = '0;
            next_acc = cyc + 1;
            hq.delete();
            gq.delete();
            g_last   = '0;
         end else begin
            gi = int'(gemm_addr[7:4]);
            if (gemm_en && !gemm_rdwr)
               gq.push_back({mdl[gi][3], mdl[gi][2], mdl[gi][1], mdl[gi][0]});
            if (gemm_en && gemm_rdwr)
               for (int l = 0; l < 4; l++)
                  if (gemm_control[l]) mdl[gi][l] = gemm_wr_data[l];
            if (h_pend) begin
               if (gemm_en) begin
                  if (m_stall != 16'hFFFF) m_stall++;
               end else begin
                  e.cyc = cyc;
                  if (h_rdwr) begin
                     mdl[h_idx][h_lane] = h_wdata;
                     e.data = '0;
                  end else begin
                     e.data = mdl[h_idx][h_lane];
                  end
                  e.stall  = m_stall;
                  hq.push_back(e);
                  h_pend   = 1'b0;
                  next_acc = cyc + 2;
               end
            end else if (sys_en && cyc >= next_acc) begin
               h_pend  = 1'b1;
               h_rdwr  = sys_rdwr;
               h_idx   = int'(sys_addr[7:4]);
               h_lane  = int'(sys_addr[3:2]);
               h_wdata = sys_wr_data;
            end
         end
      end
   end

   // Monitor: compares DUT outputs against scoreboard entries away from the active edge.
   initial begin
      host_exp_t e;
      logic [127:0] g;
      wait (mon_on);
      forever begin
         @(negedge clk);
         if (gq.size() > 0) begin
            g = gq.pop_front();
            chk("gemm_rd_data", gemm_rd_data, g);
            g_last = g;
         end else begin
            chk("gemm_rd_hold", gemm_rd_data, g_last);
         end
         if (sys_done === 1'b1) begin
            if (hq.size() == 0) begin
               chk("sys_done_unexpected", 128'(sys_done), 128'(0));
            end else begin
               e = hq.pop_front();
               chk("sys_rd_data", 128'(sys_rd_data), 128'(e.data));
               chk("sys_done_cycle", 128'(cyc), 128'(e.cyc));
               chk("stall_count", 128'(stall_count), 128'(e.stall));
            end
         end
      end
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_gemm_rd_data", gemm_rd_data, 128'h0);
      chk("rst_sys_rd_data", 128'(sys_rd_data), 128'h0);
      chk("rst_sys_done", 128'(sys_done), 128'h0);
      chk("rst_sys_ready", 128'(sys_ready), 128'h1);
      chk("rst_stall_count", 128'(stall_count), 128'h0);
      chk("rst_parity_err", 128'(parity_err), 128'h0);
      mon_on = 1'b1;

      // Fill every line so the model knows all contents.
      for (int l = 0; l < int'(DL); l++) begin
         gemm_en = 1'b1; gemm_rdwr = 1'b1; gemm_addr = 32'(l) << 4;
         gemm_control = {1'($urandom()), 4'hF};
         for (int k = 0; k < 4; k++) gemm_wr_data[k] = $urandom();
         step();
      end
      idle_inputs();
      step();

      // Full-line write then read.
      gemm_en = 1'b1; gemm_rdwr = 1'b1; gemm_addr = 32'h40; gemm_control = 5'h0F;
      gemm_wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
      step();
      gemm_rdwr = 1'b0; gemm_control = '0;
      step();
      idle_inputs();
      chk("full_write_read", gemm_rd_data, 128'h00000044_00000033_00000022_00000011);

      // Lane-masked write: only lane 1 may change.
      gemm_en = 1'b1; gemm_rdwr = 1'b1; gemm_addr = 32'h40; gemm_control = 5'h02;
      gemm_wr_data = {32'hAAAA5555, 32'h12345678, 32'hDEADBEEF, 32'h87654321};
      step();
      gemm_rdwr = 1'b0; gemm_control = '0;
      step();
      idle_inputs();
      chk("partial_write_read", gemm_rd_data, 128'h00000044_00000033_DEADBEEF_00000011);

      // Host write, engine idle: done two cycles after accept.
      sys_en = 1'b1; sys_rdwr = 1'b1; sys_addr = 32'h48; sys_wr_data = 32'hCAFEF00D;
      chk("ready_before_accept", 128'(sys_ready), 128'h1);
      step();
      idle_inputs();
      chk("ready_after_accept", 128'(sys_ready), 128'h0);
      step();
      chk("host_write_done", 128'(sys_done), 128'h1);
      gemm_en = 1'b1; gemm_rdwr = 1'b0; gemm_addr = 32'h40;
      step();
      idle_inputs();
      chk("host_write_visible", gemm_rd_data, 128'h00000044_CAFEF00D_DEADBEEF_00000011);

      // Reset while a host request is blocked: request dropped, memory kept.
      step();
      sys_en = 1'b1; sys_rdwr = 1'b0; sys_addr = 32'h48;
      step();
      sys_en = 1'b0;
      gemm_en = 1'b1; gemm_rdwr = 1'b0; gemm_addr = $urandom();
      repeat (3) step();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_sys_ready", 128'(sys_ready), 128'h1);
      chk("midrst_stall", 128'(stall_count), 128'h0);
      step();
      chk("midrst_no_done", 128'(sys_done), 128'h0);

      // Host read blocked for five engine cycles.
      sys_en = 1'b1; sys_rdwr = 1'b0; sys_addr = 32'h48;
      step();
      sys_en = 1'b0;
      gemm_en = 1'b1; gemm_rdwr = 1'b0; gemm_addr = $urandom();
      repeat (5) step();
      idle_inputs();
      step();
      chk("stall5_done", 128'(sys_done), 128'h1);
      chk("stall5_rd_data", 128'(sys_rd_data), 128'hCAFEF00D);
      chk("stall5_count", 128'(stall_count), 128'd5);
      step();

      // Randomized mixed traffic with aliasing addresses.
      for (int n = 0; n < 3000; n++) begin
         gemm_en      = ($urandom_range(2) == 0);
         gemm_rdwr    = 1'($urandom());
         gemm_addr    = $urandom();
         gemm_control = 5'($urandom());
         for (int k = 0; k < 4; k++) gemm_wr_data[k] = $urandom();
         sys_en       = 1'($urandom());
         sys_rdwr     = 1'($urandom());
         sys_addr     = $urandom();
         sys_wr_data  = $urandom();
         step();
      end
      idle_inputs();
      for (int w = 0; w < 20 && hq.size() > 0; w++) step();
      repeat (3) step();

      // Stall counter saturation.
      sys_en = 1'b1; sys_rdwr = 1'b1; sys_addr = 32'h34; sys_wr_data = 32'h600DF00D;
      step();
      sys_en = 1'b0;
      gemm_en = 1'b1; gemm_rdwr = 1'b0; gemm_addr = 32'h0;
      repeat (65546) step();
      idle_inputs();
      step();
      chk("sat_done", 128'(sys_done), 128'h1);
      chk("sat_stall_count", 128'(stall_count), 128'hFFFF);
      repeat (2) step();

`ifdef GEMM_TILE_MEM_PARITY_EN
      chk("parity_clean", 128'(parity_err), 128'h0);
      mdl[3][1] = mdl[3][1] ^ 32'h1;
      dut.g_lane[1].u_lane.mem_q[3] = dut.g_lane[1].u_lane.mem_q[3] ^ 33'h1;
      gemm_en = 1'b1; gemm_rdwr = 1'b0; gemm_addr = 32'h30;
      step();
      idle_inputs();
      step();
      chk("parity_set", 128'(parity_err), 128'h1);
      repeat (4) step();
      chk("parity_sticky", 128'(parity_err), 128'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("parity_cleared", 128'(parity_err), 128'h0);
`else
      chk("parity_tied_low", 128'(parity_err), 128'h0);
`endif

      for (int w = 0; w < 20 && hq.size() > 0; w++) step();
      if (hq.size() > 0) chk("drain_timeout", 128'(hq.size()), 128'h0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
